// File: rtl/parking_pkg.sv
// Shared types and constants for the parking entry gate.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parking_pkg;

  localparam int CAP_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    GUARD = 2'd2
  } state_t;

  // Timer must hold values up to max(OPEN_CYCLES, GUARD_CYCLES) - 1.
  function automatic int tmr_width(input int open_cycles, input int guard_cycles);
    int m;
    m = (open_cycles > guard_cycles) ? open_cycles : guard_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge qualifier for a level sensor: rise = level now, low last cycle.
// Latency: combinational pulse in the same cycle the level is first sampled high.
// Backpressure: none; a held level yields exactly one pulse.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next history value is simply the current sample.
  always_comb begin
    prev_d = level;
  end

  // History register, cleared so a level already high after reset counts once.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Entry-gate sequencer (IDLE/OPEN/GUARD) plus saturating free-space counter.
// Latency: gate and count change one cycle after the qualifying clock edge.
// Backpressure: none; enable is ignored outside IDLE, tailgaters are not counted.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter logic [CAP_W-1:0] CAPACITY     = 8'd200,
  parameter int               OPEN_CYCLES  = 16,
  parameter int               GUARD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             car_passed,
  input  logic             car_exit,
  output logic [CAP_W-1:0] parking_capacity,
  output logic             gate_open,
  output logic             full,
  output logic             timeout
);

  localparam int               TMR_W      = tmr_width(OPEN_CYCLES, GUARD_CYCLES);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(GUARD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CAP_W-1:0]   cnt_q, cnt_d;
  logic               gate_q, gate_d;
  logic               tmo_q, tmo_d;
  logic               entry;
  logic               pass_rise;
  logic               exit_rise;

  edge_detector u_pass_edge (
    .clk   (clk),
    .rst   (rst),
    .level (car_passed),
    .rise  (pass_rise)
  );

  edge_detector u_exit_edge (
    .clk   (clk),
    .rst   (rst),
    .level (car_exit),
    .rise  (exit_rise)
  );

  // Next state, shared timer, registered gate command and timeout pulse.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    gate_d  = 1'b0;
    tmo_d   = 1'b0;
    entry   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = OPEN;
          tmr_d   = '0;
          gate_d  = 1'b1;
        end
      end
      OPEN: begin
        gate_d = 1'b1;
        tmr_d  = tmr_q + TMR_ONE;
        if (pass_rise) begin
          // A car takes priority over a timeout landing on the same edge.
          entry   = 1'b1;
          state_d = GUARD;
          tmr_d   = '0;
          gate_d  = 1'b0;
        end else if (tmr_q == OPEN_LAST) begin
          tmo_d   = 1'b1;
          state_d = GUARD;
          tmr_d   = '0;
          gate_d  = 1'b0;
        end
      end
      GUARD: begin
        tmr_d = tmr_q + TMR_ONE;
        if (tmr_q == GUARD_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Free-space count: bounds are checked before the add/sub so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (entry && !exit_rise) begin
      if (cnt_q != '0) cnt_d = cnt_q - CAP_W'(1);
    end else if (exit_rise && !entry) begin
      if (cnt_q < CAPACITY) cnt_d = cnt_q + CAP_W'(1);
    end
  end

  // State and datapath registers; reset wins over any simultaneous event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= CAPACITY;
      gate_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      tmo_q   <= tmo_d;
    end
  end

  assign parking_capacity = cnt_q;
  assign gate_open        = gate_q;
  assign timeout          = tmo_q;
  assign full             = (cnt_q == '0);

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench: stimulus pushes hand-computed expectations, a monitor compares.
// Two instances: default capacity 200 and a capacity-2 instance for the fill case.
// Each expectation is due one clock edge after its inputs are applied.
module tb_parking_gate_controller;

  logic       clk;
  logic       rst_a, en_a, cp_a, ce_a;
  logic       rst_b, en_b, cp_b, ce_b;
  logic [7:0] cap_a, cap_b;
  logic       gate_a, gate_b, full_a, full_b, tmo_a, tmo_b;

  typedef struct {
    int         due;
    bit         sel;
    logic [7:0] cap;
    logic       gate;
    logic       full;
    logic       tmo;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    cyc;
  bit    sel;
  bit    done;
  bit    drained;
  int    checks;
  int    errors;

  parking_gate_controller dut_a (
    .clk              (clk),
    .rst              (rst_a),
    .enable           (en_a),
    .car_passed       (cp_a),
    .car_exit         (ce_a),
    .parking_capacity (cap_a),
    .gate_open        (gate_a),
    .full             (full_a),
    .timeout          (tmo_a)
  );

  parking_gate_controller #(.CAPACITY(8'd2)) dut_b (
    .clk              (clk),
    .rst              (rst_b),
    .enable           (en_b),
    .car_passed       (cp_b),
    .car_exit         (ce_b),
    .parking_capacity (cap_b),
    .gate_open        (gate_b),
    .full             (full_b),
    .timeout          (tmo_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: on each falling edge compare every expectation that has come due.
  initial begin
    int         rd_idx;
    exp_t       e;
    string      nm;
    logic [7:0] a_cap;
    logic       a_gate, a_full, a_tmo;
    rd_idx  = 0;
    checks  = 0;
    errors  = 0;
    drained = 1'b0;
    forever begin
      @(negedge clk);
      while (rd_idx < sb_q.size() && sb_q[rd_idx].due <= cyc) begin
        e  = sb_q[rd_idx];
        nm = nm_q[rd_idx];
        rd_idx = rd_idx + 1;
        a_cap  = e.sel ? cap_b  : cap_a;
        a_gate = e.sel ? gate_b : gate_a;
        a_full = e.sel ? full_b : full_a;
        a_tmo  = e.sel ? tmo_b  : tmo_a;
        checks = checks + 1;
        if (a_cap !== e.cap || a_gate !== e.gate || a_full !== e.full || a_tmo !== e.tmo) begin
          errors = errors + 1;
          $display("FAIL %s (cycle %0d): got cap=%0d gate=%b full=%b timeout=%b, want cap=%0d gate=%b full=%b timeout=%b",
                   nm, cyc, a_cap, a_gate, a_full, a_tmo, e.cap, e.gate, e.full, e.tmo);
        end
      end
      if (done && !drained) begin
        drained = 1'b1;
        checks  = checks + 1;
        if (rd_idx != sb_q.size()) begin
          errors = errors + 1;
          $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb_q.size() - rd_idx);
        end
      end
    end
  end

  // Apply one cycle of inputs to the selected instance and record the outputs
  // expected after the next rising edge.
  task automatic step(input logic r, input logic e, input logic p, input logic x,
                      input logic [7:0] cap, input logic g, input logic f, input logic t,
                      input string nm);
    exp_t ex;
    if (!sel) begin
      rst_a = r; en_a = e; cp_a = p; ce_a = x;
    end else begin
      rst_b = r; en_b = e; cp_b = p; ce_b = x;
    end
    ex.due  = cyc + 1;
    ex.sel  = sel;
    ex.cap  = cap;
    ex.gate = g;
    ex.full = f;
    ex.tmo  = t;
    sb_q.push_back(ex);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    sel  = 1'b0;
    done = 1'b0;
    rst_a = 1'b1; en_a = 1'b0; cp_a = 1'b0; ce_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; cp_b = 1'b0; ce_b = 1'b0;
    @(posedge clk);
    #1;

    // Capacity 200: admission, guard, held sensor, timeout.
    step(1, 0, 0, 0, 200, 0, 0, 0, "reset");
    step(0, 1, 0, 0, 200, 1, 0, 0, "enable_opens");
    step(0, 0, 1, 0, 199, 0, 0, 0, "pass_dec_close");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 199, 0, 0, 0, "guard_ignores_enable");
    step(0, 1, 1, 0, 199, 0, 0, 0, "guard_to_idle");
    step(0, 1, 1, 0, 199, 1, 0, 0, "reopen_after_guard");
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 199, 1, 0, 0, "held_pass_stays_open");
    step(0, 0, 1, 0, 199, 0, 0, 1, "timeout_pulse");
    step(0, 0, 0, 0, 199, 0, 0, 0, "timeout_one_cycle");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 199, 0, 0, 0, "guard_after_timeout");
    step(0, 1, 0, 0, 199, 1, 0, 0, "reopen_after_timeout");

    // Simultaneous events, exit saturation, mid-operation reset.
    step(0, 0, 1, 1, 199, 0, 0, 0, "entry_exit_same_edge");
    step(0, 0, 0, 0, 199, 0, 0, 0, "guard_t1");
    step(0, 0, 0, 1, 200, 0, 0, 0, "exit_inc_in_guard");
    step(0, 0, 0, 0, 200, 0, 0, 0, "guard_t3");
    step(0, 0, 0, 1, 200, 0, 0, 0, "exit_at_capacity_dropped");
    step(0, 1, 0, 1, 200, 1, 0, 0, "open_exit_held");
    step(1, 0, 1, 0, 200, 0, 0, 0, "reset_mid_open");
    step(0, 0, 1, 1, 200, 0, 0, 0, "post_reset_idle");
    step(0, 1, 0, 0, 200, 1, 0, 0, "open_after_reset");

    // Capacity 2: fill to zero, full flag, exit releases a space.
    sel = 1'b1;
    step(1, 0, 0, 0, 2, 0, 0, 0, "b_reset");
    step(0, 1, 0, 0, 2, 1, 0, 0, "b_open1");
    step(0, 0, 1, 0, 1, 0, 0, 0, "b_admit1");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0, 0, "b_guard1");
    step(0, 1, 0, 0, 1, 1, 0, 0, "b_open2");
    step(0, 0, 1, 0, 0, 0, 1, 0, "b_admit2_full");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 0, "b_guard2");
    step(0, 0, 0, 0, 0, 0, 1, 0, "b_no_enable_closed");
    step(0, 0, 0, 1, 1, 0, 0, 0, "b_exit_unfull");
    step(0, 0, 0, 1, 1, 0, 0, 0, "b_exit_held");
    step(0, 0, 0, 0, 1, 0, 0, 0, "b_idle_end");

    repeat (3) @(posedge clk);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
